// File: rtl/game_pkg.sv
// Shared state encoding, default tuning constants and width helper for the
// multi-level pinball game controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SERVE       = 3'd1,
        PLAY        = 3'd2,
        LEVEL_CLEAR = 3'd3,
        GAME_OVER   = 3'd4
    } game_state_e;

    localparam int DEF_LIFE_INIT   = 3;
    localparam int DEF_LIFE_MAX    = 9;
    localparam int DEF_PTS_GOOD    = 2;
    localparam int DEF_PTS_CREDIT  = 1;
    localparam int DEF_PEN_BAD     = 1;
    localparam int DEF_BONUS_EVERY = 20;
    localparam int DEF_LEVEL_PTS   = 10;
    localparam int DEF_CLEAR_HOLD  = 50;

    // Level and bonus accumulators share this width; wide enough for any sane threshold.
    localparam int ACC_W = 16;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_controller_lvl_key_edge.sv
// Rising-edge detector for the serve/restart key: one register, one-cycle pulse.
module key_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic edge_o
);

    logic key_q;

    // Previous key level.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key_i;
        end
    end

    assign edge_o = key_i & ~key_q;

endmodule

// File: rtl/game_controller_lvl.sv
// Multi-level pinball game sequencer: serve, play, level-clear hold and game over.
// Optional macro HIGH_SCORE_EN adds a high_score output latched on game over.
module game_controller_lvl
    import game_pkg::*;
#(
    parameter int SCORE_W     = 8,
    parameter int LIFE_W      = 4,
    parameter int LIFE_INIT   = DEF_LIFE_INIT,
    parameter int LIFE_MAX    = DEF_LIFE_MAX,
    parameter int PTS_GOOD    = DEF_PTS_GOOD,
    parameter int PTS_CREDIT  = DEF_PTS_CREDIT,
    parameter int PEN_BAD     = DEF_PEN_BAD,
    parameter int BONUS_EVERY = DEF_BONUS_EVERY,
    parameter int NUM_LEVELS  = 4,
    parameter int LEVEL_PTS   = DEF_LEVEL_PTS,
    parameter int CLEAR_HOLD  = DEF_CLEAR_HOLD,
    parameter int LEVEL_W     = idx_width(NUM_LEVELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               key5IsPressed,
    input  logic               collisionBallObstacle,
    input  logic               collisionBallObstacleGood,
    input  logic               collisionBallObstacleBad,
    input  logic               collisionBallBottom,
    input  logic               collisionBallCredit,
    output logic               pause,
    output logic               reset_level,
    output logic               reset_level_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [LIFE_W-1:0]  life,
    output logic [LEVEL_W-1:0] level,
    output logic               game_over,
    output logic               level_up_pulse
`ifdef HIGH_SCORE_EN
    ,
    output logic [SCORE_W-1:0] high_score
`endif
);

    localparam int                 HOLD_W     = idx_width(CLEAR_HOLD);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W:0]   PEN_V      = (SCORE_W+1)'(PEN_BAD);
    localparam logic [LIFE_W-1:0]  LIFE_INI_V = LIFE_W'(LIFE_INIT);
    localparam logic [LIFE_W-1:0]  LIFE_MAX_V = LIFE_W'(LIFE_MAX);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [ACC_W-1:0]   LVL_PTS_V  = ACC_W'(LEVEL_PTS);
    localparam logic [ACC_W-1:0]   BONUS_V    = ACC_W'(BONUS_EVERY);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(CLEAR_HOLD - 1);

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIFE_W-1:0]  life_q, life_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [ACC_W-1:0]   lvl_acc_q, lvl_acc_d;
    logic [ACC_W-1:0]   bonus_acc_q, bonus_acc_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               pause_q, pause_d;
    logic               rl_q, rl_d;
    logic               rl_dly_q;
    logic               game_over_q, game_over_d;
    logic               level_up_q, level_up_d;

    logic               key_edge_s;
    logic               add_s;
    logic [ACC_W-1:0]   pts_s;
    logic [SCORE_W:0]   score_sum_s;
    logic [ACC_W-1:0]   lvl_sum_s;
    logic [ACC_W-1:0]   bonus_sum_s;

    key_edge_detect u_key_edge (
        .clk    (clk),
        .reset  (reset),
        .key_i  (key5IsPressed),
        .edge_o (key_edge_s)
    );

    // Next-state, scoring arithmetic and registered-output decode.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        life_d      = life_q;
        level_d     = level_q;
        lvl_acc_d   = lvl_acc_q;
        bonus_acc_d = bonus_acc_q;
        hold_d      = hold_q;
        add_s       = 1'b0;
        pts_s       = '0;
        score_sum_s = '0;
        lvl_sum_s   = '0;
        bonus_sum_s = '0;

        case (state_q)
            IDLE: begin
                if (start) state_d = SERVE;
                else       state_d = IDLE;
            end
            SERVE: begin
                if (key_edge_s) state_d = PLAY;
                else            state_d = SERVE;
            end
            PLAY: begin
                if (collisionBallBottom) begin
                    life_d = life_q - LIFE_W'(1);
                    if (life_q <= LIFE_W'(1)) state_d = GAME_OVER;
                    else                      state_d = SERVE;
                end else if (collisionBallObstacle && collisionBallObstacleGood) begin
                    add_s = 1'b1;
                    pts_s = ACC_W'(PTS_GOOD);
                end else if (collisionBallObstacle && collisionBallObstacleBad) begin
                    // Penalty only touches the score; progression accumulators keep earned points.
                    if ({1'b0, score_q} > PEN_V) score_d = score_q - PEN_V[SCORE_W-1:0];
                    else                         score_d = '0;
                end else if (collisionBallCredit) begin
                    add_s = 1'b1;
                    pts_s = ACC_W'(PTS_CREDIT);
                end else begin
                    add_s = 1'b0;
                end

                if (add_s) begin
                    score_sum_s = {1'b0, score_q} + (SCORE_W+1)'(pts_s);
                    if (score_sum_s[SCORE_W]) score_d = SCORE_MAX;
                    else                      score_d = score_sum_s[SCORE_W-1:0];

                    bonus_sum_s = bonus_acc_q + pts_s;
                    if ((BONUS_EVERY > 0) && (bonus_sum_s >= BONUS_V)) begin
                        bonus_acc_d = bonus_sum_s - BONUS_V;
                        if (life_q < LIFE_MAX_V) life_d = life_q + LIFE_W'(1);
                        else                     life_d = life_q;
                    end else begin
                        bonus_acc_d = bonus_sum_s;
                    end

                    lvl_sum_s = lvl_acc_q + pts_s;
                    if (lvl_sum_s >= LVL_PTS_V) begin
                        if (level_q < LEVEL_LAST) begin
                            level_d   = level_q + LEVEL_W'(1);
                            lvl_acc_d = '0;
                            state_d   = LEVEL_CLEAR;
                        end else begin
                            lvl_acc_d = LVL_PTS_V;
                        end
                    end else begin
                        lvl_acc_d = lvl_sum_s;
                    end
                end else begin
                    score_sum_s = '0;
                end
            end
            LEVEL_CLEAR: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = SERVE;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            GAME_OVER: begin
                if (key_edge_s) begin
                    score_d     = '0;
                    life_d      = LIFE_INI_V;
                    level_d     = '0;
                    lvl_acc_d   = '0;
                    bonus_acc_d = '0;
                    state_d     = SERVE;
                end else begin
                    state_d     = GAME_OVER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pause_d     = (state_d != PLAY);
        rl_d        = (state_d == SERVE) || (state_d == LEVEL_CLEAR) || (state_d == GAME_OVER);
        game_over_d = (state_d == GAME_OVER);
        level_up_d  = (state_q == PLAY) && (state_d == LEVEL_CLEAR);
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            score_q     <= '0;
            life_q      <= LIFE_INI_V;
            level_q     <= '0;
            lvl_acc_q   <= '0;
            bonus_acc_q <= '0;
            hold_q      <= '0;
            pause_q     <= 1'b1;
            rl_q        <= 1'b0;
            rl_dly_q    <= 1'b0;
            game_over_q <= 1'b0;
            level_up_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            life_q      <= life_d;
            level_q     <= level_d;
            lvl_acc_q   <= lvl_acc_d;
            bonus_acc_q <= bonus_acc_d;
            hold_q      <= hold_d;
            pause_q     <= pause_d;
            rl_q        <= rl_d;
            rl_dly_q    <= rl_q;
            game_over_q <= game_over_d;
            level_up_q  <= level_up_d;
        end
    end

    assign pause             = pause_q;
    assign reset_level       = rl_q;
    assign reset_level_pulse = rl_q & ~rl_dly_q;
    assign score             = score_q;
    assign life              = life_q;
    assign level             = level_q;
    assign game_over         = game_over_q;
    assign level_up_pulse    = level_up_q;

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_q;

    // Best score seen, captured as a game ends; survives the restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_score_q <= '0;
        end else if ((state_q == PLAY) && (state_d == GAME_OVER) && (score_q > high_score_q)) begin
            high_score_q <= score_q;
        end else begin
            high_score_q <= high_score_q;
        end
    end

    assign high_score = high_score_q;
`endif

endmodule

// File: doc/game_controller_lvl.md
Name: game_controller_lvl

Overview:
- Parametrised successor of the single-level game controller: pause, serve, play and game-over sequencing for the pinball table.
- Adds configurable score/life widths, weighted scoring, bad-obstacle penalty, bonus lives, multi-level progression with a timed level-clear hold, and an explicit game_over flag.
- Sits between the collision detectors and the display/physics blocks. Drives pause and level-reset to the ball, flipper and obstacle logic, and score/life/level to the HUD.

Parameters:
- SCORE_W, 8, score width; score saturates at 2^SCORE_W-1.
- LIFE_W, 4, life counter width.
- LIFE_INIT, 3, lives at game start; must be at least 1 and no more than LIFE_MAX.
- LIFE_MAX, 9, bonus lives saturate here.
- PTS_GOOD, 2, points per good-obstacle hit.
- PTS_CREDIT, 1, points per credit hit.
- PEN_BAD, 1, points removed per bad-obstacle hit.
- BONUS_EVERY, 20, accumulated points per bonus life; 0 disables bonus lives.
- NUM_LEVELS, 4, number of levels; LEVEL_W = $clog2(NUM_LEVELS), minimum 1.
- LEVEL_PTS, 10, points earned within a level that clear it.
- CLEAR_HOLD, 50, cycles spent in LEVEL_CLEAR.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  leave IDLE
- key5IsPressed  in  1  level input; rising edge is detected internally
- collisionBallObstacle  in  1  ball hit some obstacle
- collisionBallObstacleGood  in  1  the obstacle hit is a good one
- collisionBallObstacleBad  in  1  the obstacle hit is a bad one
- collisionBallBottom  in  1  ball lost
- collisionBallCredit  in  1  credit target hit
- pause  out  1  freeze motion
- reset_level  out  1  hold playfield in initial position
- reset_level_pulse  out  1  one-cycle pulse on the rising edge of reset_level
- score  out  SCORE_W  current score
- life  out  LIFE_W  remaining lives
- level  out  LEVEL_W  current level, 0-based
- game_over  out  1  high while in GAME_OVER
- level_up_pulse  out  1  one-cycle pulse on entering LEVEL_CLEAR

Behaviour:
- Reset, synchronous on the clk edge with reset=1:
  - State IDLE; score=0, life=LIFE_INIT, level=0.
  - Level-points accumulator, bonus accumulator and hold counter all 0; key edge register cleared.
  - pause=1, reset_level=0, reset_level_pulse=0, game_over=0, level_up_pulse=0.
  - Reset asserted mid-game aborts immediately; there is no pending-event carry-over.
- key_edge is high for one cycle when key5IsPressed goes 0 to 1. A held key does not re-trigger.
- States:
  - IDLE: pause=1. start goes to SERVE.
  - SERVE: pause=1, reset_level=1. key_edge goes to PLAY.
  - PLAY: pause=0. One event per cycle, in this priority:
    1. collisionBallBottom: life-1. If the result is 0, go to GAME_OVER; otherwise go to SERVE.
    2. collisionBallObstacle and Good: add PTS_GOOD.
    3. collisionBallObstacle and Bad: subtract PEN_BAD, floored at 0. Level and bonus accumulators are unchanged.
    4. collisionBallCredit: add PTS_CREDIT.
    - Lower-priority events in the same cycle are dropped.
    - Good and Bad together count as Good.
  - Additions (PLAY only):
    - Score saturates at its maximum.
    - The level and bonus accumulators add the nominal points even when score saturates.
    - When the bonus accumulator reaches BONUS_EVERY or more: subtract BONUS_EVERY and add 1 life, saturating at LIFE_MAX.
    - When the level accumulator reaches LEVEL_PTS or more and level < NUM_LEVELS-1: level+1, accumulator cleared, go to LEVEL_CLEAR.
    - On the last level the accumulator saturates and there is no transition.
    - Bonus life and level-up may occur on the same cycle; both apply.
  - LEVEL_CLEAR: pause=1, reset_level=1. The hold counter runs 0 to CLEAR_HOLD-1, then goes to SERVE. The counter clears on exit. Keys are ignored.
  - GAME_OVER: pause=1, reset_level=1, game_over=1. key_edge reloads score=0, life=LIFE_INIT, level=0, clears both accumulators, and goes to SERVE.
- reset_level_pulse = reset_level & ~reset_level_d, where reset_level_d is a register that resets to 0. A LEVEL_CLEAR to SERVE transition produces no second pulse.
- All outputs except the two pulses are decoded from registered state and counters; there is no combinational path from collision inputs to outputs.

Optional Feature:
- Macro HIGH_SCORE_EN.
- Defined: adds output high_score [SCORE_W]. It is cleared by reset and updated to score on entry to GAME_OVER if score > high_score. It is not touched by the GAME_OVER restart.
- Undefined: the port and register are absent.

Decomposition:
- Package game_pkg:
  - the state enum (IDLE, SERVE, PLAY, LEVEL_CLEAR, GAME_OVER), 3 bits;
  - default constants LIFE_INIT, LIFE_MAX, PTS_*, PEN_BAD, BONUS_EVERY, LEVEL_PTS, CLEAR_HOLD.
- One sub-module, key_edge_detect: one register and a rising-edge pulse, synchronous active-high reset.
- Scoring arithmetic stays inline.

Test Plan:
- Reset, start, key_edge -> SERVE gives reset_level_pulse once. PLAY with pause=0, score=0, life=3, level=0.
- Five good hits (PTS_GOOD=2) -> score=10, level_up_pulse once, level=1. LEVEL_CLEAR lasts exactly 50 cycles, then SERVE.
- Score=0, bad hit -> score stays 0. Bottom and good in the same cycle -> life 3 to 2, score unchanged, state SERVE.
- Ten good hits with BONUS_EVERY=20 -> life+1. With life at 9, a further bonus keeps life=9.
- Three bottoms -> GAME_OVER with game_over=1. Held key gives one restart to score 0, life 3, level 0. With HIGH_SCORE_EN, high_score holds the pre-game-over score.
- reset asserted during LEVEL_CLEAR hold -> next cycle IDLE, all outputs at their reset values.
